fb_display_fetch: RTL
=====================

Name: fb_display_fetch

Overview:
Display-side read stage of the 320x240x12-bit frame buffer. Takes VGA timing (hcount, vcount, hsync, vsync, blank) and the BRAM word address produced by the address mapper, then issues the read to the selected frame-buffer bank. It delays the sync and blank signals to match BRAM read latency and drives registered 4:4:4 RGB to the VGA pins. It owns the double-buffer bank select and swaps banks only at a frame boundary, under a req/ack handshake with the capture/writer side.

Parameters:
READ_LATENCY, 2, BRAM read latency in cycles from registered address to valid dout (legal 1..4)
H_ACTIVE, 640, active pixels per line in hcount space
V_ACTIVE, 480, active lines per frame in vcount space

Ports:
clk  input  1  pixel clock, all logic on rising edge
reset  input  1  synchronous, active-high
hcount  input  10  horizontal pixel counter from timing generator
vcount  input  10  vertical line counter from timing generator
hsync  input  1  horizontal sync, timing-aligned with hcount
vsync  input  1  vertical sync, timing-aligned with vcount
blank  input  1  blanking, timing-aligned with hcount
pix_addr  input  17  frame-buffer word address from address mapper, combinational from hcount/vcount this cycle
bram_addr  output  18  {display_bank, pix_addr}, registered
bram_dout  input  12  read data {r[3:0], g[3:0], b[3:0]}
swap_req  input  1  level request from writer to exchange banks
swap_ack  output  1  one-cycle pulse: swap performed
write_bank  output  1  bank the writer may fill (always ~display_bank)
vga_r  output  4  red
vga_g  output  4  green
vga_b  output  4  blue
vga_hsync  output  1  delayed hsync
vga_vsync  output  1  delayed vsync
vga_blank  output  1  delayed blank

Behaviour:
- Reset: display_bank=0, write_bank=1, bram_addr=0, swap_ack=0, vga_r/g/b=0, vga_hsync/vga_vsync/vga_blank=0. All delay-pipeline stages cleared to 0, including valid/active flags. Reset mid-frame takes effect on the next edge. Output stays black until the pipeline refills with post-reset samples.
- Pipeline, with inputs sampled at cycle T:
  - T+1: bram_addr registered.
  - T+1+READ_LATENCY: bram_dout valid.
  - T+2+READ_LATENCY: vga_* registered.
  - Total latency PIPE = READ_LATENCY+2 for every vga_* output, including syncs. No bubbles; one pixel accepted per clock.
- Active flag at T: active = !blank && hcount<H_ACTIVE && vcount<V_ACTIVE. It travels with the pixel. If not active, vga_r/g/b = 0 regardless of bram_dout.
- Syncs and blank are pure delays; polarity is passed through unchanged.
- Bank select:
  - bram_addr[17] is display_bank as sampled at T.
  - Frame boundary event F: hcount==0 && vcount==V_ACTIVE (first pixel of the first vblank line).
  - At F with swap_req=1: display_bank toggles on that edge and swap_ack=1 for exactly the following cycle.
  - Otherwise swap_ack=0.
  - swap_req rising in the same cycle as F counts as a request.
  - swap_req dropped before F: no swap.
  - The writer must drop swap_req on ack. If it is still high at the next F, a second swap occurs (legal, not filtered).
- Because the swap occurs during vblank, no visible pixel ever mixes banks. In-flight blank-period fetches may use either bank; their output is forced black.
- write_bank changes in the same cycle display_bank changes.
- Counter wrap (hcount/vcount returning to 0) needs no special handling; the pipeline is stateless per pixel.

Test Plan:
- Reset, then hcount=0, vcount=0, blank=0, pix_addr=0: bram_addr=0x00000 at T+1. With bram_dout=0xF0A returned per model, vga_r/g/b=F/0/A at T+4 (READ_LATENCY=2).
- hsync pulse at T, width 96, with blank=1: vga_hsync pulse starts at T+4 with width 96; vga_r/g/b=0 throughout regardless of bram_dout=0xFFF.
- hcount=639, vcount=479, pix_addr=76799: bram_addr=0x12BFF with bank 0, and the pixel is shown. hcount=640 with blank erroneously 0: output is black.
- swap_req=1 held from line 100, then F reached: display_bank 0->1, write_bank 1->0, swap_ack high for 1 cycle. The next bram_addr MSB is 1; the first visible pixel of the next frame reads bank 1.
- swap_req pulsed high at line 200 and dropped at line 300: no swap, swap_ack stays 0, bank unchanged. swap_req held through two F events: two acks, bank returns to original.
- Assert reset for 1 cycle mid-line 250 after a swap: bank=0, all vga_* outputs 0 for 4 cycles, then normal output resumes with correctly aligned syncs.

Source files
------------

// File: rtl/fb_display_fetch.sv
// Display-side read stage of the double-buffered 320x240x12 frame buffer.
// Issues the BRAM read for each pixel, delays the timing signals to match
// the BRAM read latency, and owns the display/write bank select.
module fb_display_fetch #(
  parameter int READ_LATENCY = 2,
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        blank,
  input  logic [16:0] pix_addr,
  output logic [17:0] bram_addr,
  input  logic [11:0] bram_dout,
  input  logic        swap_req,
  output logic        swap_ack,
  output logic        write_bank,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        vga_blank
);

  // Stage k of the delay lines is visible at T+1+k; the last stage lines up
  // with bram_dout, and the output registers add the final cycle.
  localparam int DEPTH = READ_LATENCY + 1;

  logic             display_bank;
  logic             frame_edge;
  logic             active_in;
  logic [DEPTH-1:0] act_d;
  logic [DEPTH-1:0] hs_d;
  logic [DEPTH-1:0] vs_d;
  logic [DEPTH-1:0] bl_d;

  assign frame_edge = (hcount == 10'd0) && (vcount == 10'(V_ACTIVE));
  assign active_in  = !blank && (hcount < 10'(H_ACTIVE)) && (vcount < 10'(V_ACTIVE));
  assign write_bank = ~display_bank;

  // Bank select: swap only at the first pixel of vblank while a request is held.
  always_ff @(posedge clk) begin
    if (reset) begin
      display_bank <= 1'b0;
      swap_ack     <= 1'b0;
    end else if (frame_edge && swap_req) begin
      display_bank <= ~display_bank;
      swap_ack     <= 1'b1;
    end else begin
      swap_ack     <= 1'b0;
    end
  end

  // Read address uses the bank in force when the pixel was presented.
  always_ff @(posedge clk) begin
    if (reset) bram_addr <= 18'd0;
    else       bram_addr <= {display_bank, pix_addr};
  end

  // Timing and active-flag delay lines covering address register + BRAM latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      act_d <= '0;
      hs_d  <= '0;
      vs_d  <= '0;
      bl_d  <= '0;
    end else begin
      act_d <= {act_d[DEPTH-2:0], active_in};
      hs_d  <= {hs_d[DEPTH-2:0],  hsync};
      vs_d  <= {vs_d[DEPTH-2:0],  vsync};
      bl_d  <= {bl_d[DEPTH-2:0],  blank};
    end
  end

  // Registered VGA outputs; pixels outside the active area are forced black.
  always_ff @(posedge clk) begin
    if (reset) begin
      vga_r     <= 4'd0;
      vga_g     <= 4'd0;
      vga_b     <= 4'd0;
      vga_hsync <= 1'b0;
      vga_vsync <= 1'b0;
      vga_blank <= 1'b0;
    end else begin
      if (act_d[DEPTH-1]) begin
        vga_r <= bram_dout[11:8];
        vga_g <= bram_dout[7:4];
        vga_b <= bram_dout[3:0];
      end else begin
        vga_r <= 4'd0;
        vga_g <= 4'd0;
        vga_b <= 4'd0;
      end
      vga_hsync <= hs_d[DEPTH-1];
      vga_vsync <= vs_d[DEPTH-1];
      vga_blank <= bl_d[DEPTH-1];
    end
  end

endmodule
